csi_tx_packetizer: RTL and testbench

//  CSI-2 transmit framer for a 2-lane link; counterpart of the receive-side header finder.
//  - Accepts packet commands (VC, DT, WC) and a 16-bit payload stream.
//  - Emits per-lane sync, a 4-byte packet header with ECC, the payload and a CRC-16 footer.
//  - Output is one byte per lane per cycle, toward the PHY serializers.

---
 rtl/csi_pkg.sv | 32 +++
 rtl/csi_tx_packetizer_if.sv | 24 ++
 rtl/csi_crc16_2b.sv | 29 ++
 rtl/csi_tx_packetizer.sv | 159 +++++++++++++++
 tb/tb_csi_tx_packetizer.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csi_pkg.sv
// rtl/csi_pkg.sv - shared CSI-2 framing types, constants and header ECC
package csi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_HDR0,
    ST_HDR1,
    ST_PAYLOAD,
    ST_FOOTER,
    ST_GAP
  } csi_state_e;

  localparam logic [7:0] SYNC_BYTE    = 8'hB8;
  localparam logic [5:0] SHORT_DT_MAX = 6'h0F;
  localparam logic [5:0] DT_FS        = 6'h00;
  localparam logic [5:0] DT_FE        = 6'h01;
  localparam logic [5:0] DT_RAW8      = 6'h2A;

  // Header Hamming parity over D0..D23, D0 = DI[0], D23 = WC_hi[7]
  function automatic logic [5:0] csi_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

endpackage

// File: rtl/csi_tx_packetizer_if.sv
// rtl/csi_tx_packetizer_if.sv - command, payload and lane output bundle of the CSI-2 TX framer
interface csi_tx_packetizer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_vc;
  logic [5:0]  cmd_dt;
  logic [15:0] cmd_wc;
  logic [15:0] pay_data;
  logic        pay_valid;
  logic        pay_ready;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_last;

  modport master (
    output cmd_valid, cmd_vc, cmd_dt, cmd_wc, pay_data, pay_valid,
    input  cmd_ready, pay_ready, dout, dout_valid, dout_last
  );

  modport slave (
    input  cmd_valid, cmd_vc, cmd_dt, cmd_wc, pay_data, pay_valid,
    output cmd_ready, pay_ready, dout, dout_valid, dout_last
  );
endinterface

// File: rtl/csi_crc16_2b.sv
// rtl/csi_crc16_2b.sv - reflected CRC-16 (0x8408) over two bytes per cycle, low byte first
module csi_crc16_2b (
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [15:0] data,
  output logic [15:0] crc
);

  // Bit-serial LSB-first update; data[7:0] is consumed before data[15:8]
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 16; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // CRC register: seed on init, fold in one payload word per enabled cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    crc <= 16'hFFFF;
    else if (init) crc <= 16'hFFFF;
    else if (en)   crc <= crc_step(crc, data);
  end

endmodule

// File: rtl/csi_tx_packetizer.sv
// rtl/csi_tx_packetizer.sv - CSI-2 2-lane TX framer (sync, header+ECC, payload, CRC footer); CSI_TX_CRC_EN enables the footer CRC
module csi_tx_packetizer
  import csi_pkg::*;
#(
  parameter int GAP_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  csi_tx_packetizer_if.slave bus,
  output logic              busy,
  output logic              err_odd_wc,
  output logic              err_underrun
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  csi_state_e    state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [14:0]   rem_q, rem_d;
  logic [1:0]    vc_q;
  logic [5:0]    dt_q;
  logic [15:0]   wc_q;
  logic          cmd_fire, cmd_take, is_short, is_odd_long;
  logic [7:0]    di, ecc_byte;
  logic [15:0]   pay_word, footer;
  logic [15:0]   dout_d;
  logic          valid_d, last_d, odd_d, und_d;

  assign di          = {vc_q, dt_q};
  assign ecc_byte    = {2'b00, csi_ecc({wc_q, di})};
  assign is_short    = (dt_q <= SHORT_DT_MAX);
  // Held low during reset so every output reads 0 while reset is asserted
  assign bus.cmd_ready = reset && (state_q == ST_IDLE) && (gap_q == '0);
  assign cmd_fire    = bus.cmd_valid && bus.cmd_ready;
  assign is_odd_long = (bus.cmd_dt > SHORT_DT_MAX) && bus.cmd_wc[0];
  // High exactly when the next dout word is payload
  assign bus.pay_ready = ((state_q == ST_HDR1) && !is_short && (wc_q != 16'h0000)) ||
                         ((state_q == ST_PAYLOAD) && (rem_q != '0));
  // A missing word still occupies its slot as zeros, and the CRC sees those zeros
  assign pay_word    = bus.pay_valid ? bus.pay_data : 16'h0000;
  assign busy        = (state_q != ST_IDLE) || (gap_q != '0);

`ifdef CSI_TX_CRC_EN
  logic [15:0] crc;
  logic        crc_init;

  // Seeded on entry to HDR1 so a zero-length packet carries 0xFFFF
  assign crc_init = (state_d == ST_HDR1);

  csi_crc16_2b u_crc (
    .clk   (clk),
    .reset (reset),
    .init  (crc_init),
    .en    (bus.pay_ready),
    .data  (pay_word),
    .crc   (crc)
  );

  assign footer = crc;
`else
  assign footer = 16'h0000;
`endif

  // Next state, counters and the word to register onto the lanes
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    rem_d    = rem_q;
    cmd_take = 1'b0;
    odd_d    = 1'b0;
    dout_d   = 16'h0000;
    valid_d  = 1'b0;
    last_d   = 1'b0;
    und_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (is_odd_long) begin
            odd_d = 1'b1;
          end else begin
            cmd_take = 1'b1;
            state_d  = ST_SYNC;
          end
        end
      end
      ST_SYNC: state_d = ST_HDR0;
      ST_HDR0: state_d = ST_HDR1;
      ST_HDR1: begin
        if (is_short) begin
          state_d = ST_GAP;
          gap_d   = GW'(GAP_CYCLES);
        end else if (wc_q == 16'h0000) begin
          state_d = ST_FOOTER;
        end else begin
          state_d = ST_PAYLOAD;
          rem_d   = wc_q[15:1] - 15'd1;
        end
      end
      ST_PAYLOAD: begin
        if (rem_q != '0) rem_d = rem_q - 15'd1;
        else             state_d = ST_FOOTER;
      end
      ST_FOOTER: begin
        state_d = ST_GAP;
        gap_d   = GW'(GAP_CYCLES);
      end
      ST_GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q <= GW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_SYNC:    begin dout_d = {SYNC_BYTE, SYNC_BYTE}; valid_d = 1'b1; end
      ST_HDR0:    begin dout_d = {wc_q[7:0], di};        valid_d = 1'b1; end
      ST_HDR1:    begin dout_d = {ecc_byte, wc_q[15:8]}; valid_d = 1'b1; last_d = is_short; end
      ST_PAYLOAD: begin dout_d = pay_word; valid_d = 1'b1; und_d = !bus.pay_valid; end
      ST_FOOTER:  begin dout_d = footer;   valid_d = 1'b1; last_d = 1'b1; end
      default:    ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Counters, latched command and registered lane/error outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_q          <= '0;
      rem_q          <= '0;
      vc_q           <= '0;
      dt_q           <= '0;
      wc_q           <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.dout_last  <= 1'b0;
      err_odd_wc     <= 1'b0;
      err_underrun   <= 1'b0;
    end else begin
      gap_q <= gap_d;
      rem_q <= rem_d;
      if (cmd_take) begin
        vc_q <= bus.cmd_vc;
        dt_q <= bus.cmd_dt;
        wc_q <= bus.cmd_wc;
      end
      bus.dout       <= dout_d;
      bus.dout_valid <= valid_d;
      bus.dout_last  <= last_d;
      err_odd_wc     <= odd_d;
      err_underrun   <= und_d;
    end
  end

endmodule

// File: tb/tb_csi_tx_packetizer.sv
// tb/tb_csi_tx_packetizer.sv - scoreboard bench for the CSI-2 TX framer (CSI_TX_CRC_EN selects expected footer)
module tb_csi_tx_packetizer;
  import csi_pkg::*;

  localparam int GAP = 8;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy, err_odd_wc, err_underrun;
  int   checks = 0;
  int   errors = 0;
  int   und_cnt = 0;
  int   odd_cnt = 0;

  exp_t        exp_q[$];
  logic [16:0] pay_q[$];

  logic [5:0] ecc_tbl [24] = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                               6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                               6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  csi_tx_packetizer_if bus ();

  csi_tx_packetizer #(.GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .busy         (busy),
    .err_odd_wc   (err_odd_wc),
    .err_underrun (err_underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ecc_model(input logic [23:0] d);
    logic [5:0] e;
    e = '0;
    for (int i = 0; i < 24; i++) if (d[i]) e ^= ecc_tbl[i];
    return e;
  endfunction

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_w(input logic [15:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
    int n;
    @(posedge clk);
    #1;
    bus.cmd_vc    = vc;
    bus.cmd_dt    = dt;
    bus.cmd_wc    = wc;
    bus.cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 200);
    chk("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
    logic [7:0]  di;
    logic [15:0] crc, w;
    logic        sh;
    di  = {vc, dt};
    sh  = (dt <= 6'h0F);
    crc = 16'hFFFF;
    push_w(16'hB8B8, 1'b0);
    push_w({wc[7:0], di}, 1'b0);
    push_w({2'b00, ecc_model({wc, di}), wc[15:8]}, sh);
    if (!sh) begin
      foreach (pay_q[i]) begin
        w = pay_q[i][16] ? pay_q[i][15:0] : 16'h0000;
        push_w(w, 1'b0);
        crc = crc_byte(crc_byte(crc, w[7:0]), w[15:8]);
      end
`ifndef CSI_TX_CRC_EN
      crc = 16'h0000;
`endif
      push_w(crc, 1'b1);
    end
    issue(vc, dt, wc);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 1000), 32'd1);
  endtask

  // Output monitor: pops the scoreboard on every valid lane word
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (err_underrun) und_cnt++;
      if (err_odd_wc) odd_cnt++;
      if (bus.dout_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_dout_valid", 32'(bus.dout_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("dout", 32'(bus.dout), 32'(e.d));
          chk("dout_last", 32'(bus.dout_last), 32'(e.l));
        end
      end else begin
        chk("idle_dout_zero", 32'({bus.dout, bus.dout_last}), 32'd0);
      end
    end
  end

  // Payload source: presents the queue head, pops it on each consumed slot
  initial begin
    logic take;
    bus.pay_valid = 1'b0;
    bus.pay_data  = 16'h0000;
    forever begin
      @(negedge clk);
      take = bus.pay_ready;
      @(posedge clk);
      #1;
      if (take && pay_q.size() > 0) void'(pay_q.pop_front());
      if (pay_q.size() > 0) begin
        bus.pay_valid = pay_q[0][16];
        bus.pay_data  = pay_q[0][15:0];
      end else begin
        bus.pay_valid = 1'b0;
        bus.pay_data  = 16'h0000;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, u0, o0;
    logic [1:0]  rvc;
    logic [5:0]  rdt;
    logic [15:0] rwc;
    bus.cmd_valid = 1'b0;
    bus.cmd_vc    = '0;
    bus.cmd_dt    = '0;
    bus.cmd_wc    = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", 32'({bus.dout, bus.dout_valid, bus.dout_last, bus.pay_ready,
                         err_odd_wc, err_underrun}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_reset", 32'(bus.cmd_ready), 32'd1);

    // 1: short FS and gap length
    push_w(16'hB8B8, 1'b0);
    push_w(16'h0000, 1'b0);
    push_w(16'h0000, 1'b1);
    issue(2'd0, DT_FS, 16'h0000);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(bus.dout_valid && bus.dout_last) && n < 20);
    chk("fs_last_seen", 32'(n < 20), 32'd1);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      if (n == 0) chk("busy_in_gap", 32'(busy), 32'd1);
      n++;
    end
    chk("gap_cycles", 32'(n), 32'(GAP));

    // 2: fixed ECC vectors, then random short headers
    push_w(16'hB8B8, 1'b0);
    push_w(16'h0001, 1'b0);
    push_w(16'h0700, 1'b1);
    issue(2'd0, DT_FE, 16'h0000);
    push_w(16'hB8B8, 1'b0);
    push_w(16'h0100, 1'b0);
    push_w(16'h1A00, 1'b1);
    issue(2'd0, DT_FS, 16'h0001);
    for (int k = 0; k < 256; k++) begin
      rvc = 2'($urandom_range(0, 3));
      rdt = 6'($urandom_range(0, 15));
      rwc = 16'($urandom());
      send_pkt(rvc, rdt, rwc);
    end
    wait_drain();

    // 3: long RAW8, wc=4
    u0 = und_cnt;
    pay_q.push_back({1'b1, 16'h2211});
    pay_q.push_back({1'b1, 16'h4433});
    send_pkt(2'd0, DT_RAW8, 16'd4);
    wait_drain();
    chk("raw8_no_underrun", 32'(und_cnt - u0), 32'd0);

    // 4: underrun on the 2nd of 3 words
    u0 = und_cnt;
    pay_q.push_back({1'b1, 16'hA1B2});
    pay_q.push_back({1'b0, 16'h5555});
    pay_q.push_back({1'b1, 16'hC3D4});
    send_pkt(2'd1, DT_RAW8, 16'd6);
    wait_drain();
    chk("underrun_pulses", 32'(und_cnt - u0), 32'd1);

    // 5: odd WC rejected, next command accepted at N+1
    o0 = odd_cnt;
    @(posedge clk);
    #1;
    bus.cmd_vc    = 2'd0;
    bus.cmd_dt    = DT_RAW8;
    bus.cmd_wc    = 16'd5;
    bus.cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 200);
    chk("odd_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_vc = 2'd2;
    bus.cmd_dt = 6'h02;
    bus.cmd_wc = 16'h1234;
    push_w(16'hB8B8, 1'b0);
    push_w(16'h3482, 1'b0);
    push_w({2'b00, ecc_model(24'h123482), 8'h12}, 1'b1);
    @(negedge clk);
    chk("odd_err_n1", 32'(err_odd_wc), 32'd1);
    chk("odd_ready_n1", 32'(bus.cmd_ready), 32'd1);
    chk("odd_busy_n1", 32'(busy), 32'd0);
    chk("odd_no_valid", 32'(bus.dout_valid), 32'd0);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("odd_err_cleared", 32'(err_odd_wc), 32'd0);
    chk("after_odd_sync", 32'(bus.dout), 32'h0000B8B8);
    wait_drain();
    chk("odd_pulse_count", 32'(odd_cnt - o0), 32'd1);

    // 6: reset during PAYLOAD
    for (int k = 0; k < 4; k++) pay_q.push_back({1'b1, 16'($urandom())});
    push_w(16'hB8B8, 1'b0);
    push_w(16'h08EA, 1'b0);
    push_w({2'b00, ecc_model(24'h0008EA), 8'h00}, 1'b0);
    push_w(pay_q[0][15:0], 1'b0);
    issue(2'd3, DT_RAW8, 16'd8);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0) break;
      n++;
    end
    chk("reached_payload", 32'(n < 50), 32'd1);
    chk("pre_reset_valid", 32'(bus.dout_valid), 32'd1);
    chk("pre_reset_pay_ready", 32'(bus.pay_ready), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_outs", 32'({bus.dout, bus.dout_valid, bus.dout_last, bus.pay_ready,
                             bus.cmd_ready, busy, err_odd_wc, err_underrun}), 32'd0);
    pay_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    send_pkt(2'd1, 6'h05, 16'hBEEF);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
